// File: rtl/dlx_mem_pkg.sv
// Shared types for the unified instruction/data memory port.
package dlx_mem_pkg;

    typedef enum logic [1:0] {
        FMT_BYTE = 2'b00,
        FMT_HALF = 2'b01,
        FMT_WORD = 2'b10
    } mem_fmt_e;

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_FETCH = 2'd1,
        OWNER_LOAD  = 2'd2
    } owner_e;

    typedef struct packed {
        logic fetch;
        logic data;
    } grant_t;

    localparam int unsigned RUN_CNT_WIDTH = 4;

    // Which requester owns the read data returning on the next cycle.
    function automatic owner_e next_owner(input grant_t gnt, input logic we);
        owner_e own;
        own = OWNER_NONE;
        if (gnt.fetch)
            own = OWNER_FETCH;
        else if (gnt.data && !we)
            own = OWNER_LOAD;
        return own;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch port, load/store port and shared memory port bundled for the arbiter.
interface mem_port_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
);
    logic                  i_req_i;
    logic [ADDR_WIDTH-1:0] i_addr_i;
    logic                  i_gnt_o;
    logic                  i_rvalid_o;
    logic [DATA_WIDTH-1:0] i_rdata_o;

    logic                  d_req_i;
    logic                  d_we_i;
    logic [ADDR_WIDTH-1:0] d_addr_i;
    logic [DATA_WIDTH-1:0] d_wdata_i;
    logic [1:0]            d_format_i;
    logic                  d_sign_i;
    logic                  d_gnt_o;
    logic                  d_rvalid_o;
    logic [DATA_WIDTH-1:0] d_rdata_o;

    logic                  mem_en_o;
    logic                  mem_we_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_din_o;
    logic [1:0]            mem_data_format_o;
    logic                  mem_data_sign_o;
    logic [DATA_WIDTH-1:0] mem_dout_i;

    modport slave (
        input  i_req_i, i_addr_i,
        output i_gnt_o, i_rvalid_o, i_rdata_o,
        input  d_req_i, d_we_i, d_addr_i, d_wdata_i, d_format_i, d_sign_i,
        output d_gnt_o, d_rvalid_o, d_rdata_o,
        output mem_en_o, mem_we_o, mem_addr_o, mem_din_o,
        output mem_data_format_o, mem_data_sign_o,
        input  mem_dout_i
    );

    modport master (
        output i_req_i, i_addr_i,
        input  i_gnt_o, i_rvalid_o, i_rdata_o,
        output d_req_i, d_we_i, d_addr_i, d_wdata_i, d_format_i, d_sign_i,
        input  d_gnt_o, d_rvalid_o, d_rdata_o,
        input  mem_en_o, mem_we_o, mem_addr_o, mem_din_o,
        input  mem_data_format_o, mem_data_sign_o,
        output mem_dout_i
    );
endinterface

// File: rtl/mem_port_mux.sv
// Steers the shared memory port from the granted requester.
module mem_port_mux
    import dlx_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 10
) (
    input  grant_t                gnt,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [1:0]            d_format,
    input  logic                  d_sign,
    output logic                  mem_en_c,
    output logic                  mem_we_c,
    output logic [ADDR_WIDTH-1:0] mem_addr_c,
    output logic [DATA_WIDTH-1:0] mem_din_c,
    output logic [1:0]            mem_format_c,
    output logic                  mem_sign_c
);

    // Idle cycles park the address/data fields on the load/store port.
    always_comb begin
        mem_en_c     = gnt.fetch | gnt.data;
        mem_we_c     = gnt.data & d_we;
        mem_addr_c   = d_addr;
        mem_din_c    = d_wdata;
        mem_format_c = d_format;
        mem_sign_c   = d_sign;
        if (gnt.fetch) begin
            mem_addr_c   = i_addr;
            mem_din_c    = '0;
            mem_format_c = FMT_WORD;
            mem_sign_c   = 1'b0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and load/store,
// with a bounded data run so fetch always makes progress.
module mem_port_arbiter
    import dlx_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned MAX_DATA_RUN = 4
) (
    input logic               clk_i,
    input logic               rst_i,
    mem_port_arbiter_if.slave bus
);

    localparam logic [RUN_CNT_WIDTH-1:0] RUN_LIMIT = RUN_CNT_WIDTH'(MAX_DATA_RUN);

    logic [RUN_CNT_WIDTH-1:0] run_cnt;
    owner_e                   owner_q;
    grant_t                   gnt_c;

    // Data wins unless a waiting fetch has already seen RUN_LIMIT data grants.
    always_comb begin
        gnt_c = '0;
        if (!rst_i) begin
            if (bus.d_req_i && (!bus.i_req_i || (run_cnt < RUN_LIMIT)))
                gnt_c.data = 1'b1;
            else if (bus.i_req_i)
                gnt_c.fetch = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_cnt <= '0;
            owner_q <= OWNER_NONE;
        end else begin
            if (!bus.i_req_i || gnt_c.fetch)
                run_cnt <= '0;
            else if (gnt_c.data && (run_cnt < RUN_LIMIT))
                run_cnt <= run_cnt + RUN_CNT_WIDTH'(1);
            owner_q <= next_owner(gnt_c, bus.d_we_i);
        end
    end

    assign bus.i_gnt_o    = gnt_c.fetch;
    assign bus.d_gnt_o    = gnt_c.data;
    assign bus.i_rvalid_o = (owner_q == OWNER_FETCH);
    assign bus.d_rvalid_o = (owner_q == OWNER_LOAD);
    assign bus.i_rdata_o  = bus.mem_dout_i;
    assign bus.d_rdata_o  = bus.mem_dout_i;

    mem_port_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mux (
        .gnt          (gnt_c),
        .i_addr       (bus.i_addr_i),
        .d_we         (bus.d_we_i),
        .d_addr       (bus.d_addr_i),
        .d_wdata      (bus.d_wdata_i),
        .d_format     (bus.d_format_i),
        .d_sign       (bus.d_sign_i),
        .mem_en_c     (bus.mem_en_o),
        .mem_we_c     (bus.mem_we_o),
        .mem_addr_c   (bus.mem_addr_o),
        .mem_din_c    (bus.mem_din_o),
        .mem_format_c (bus.mem_data_format_o),
        .mem_sign_c   (bus.mem_data_sign_o)
    );

endmodule
